// File: rtl/fw_loader_pkg.sv
// Shared definitions for the firmware loader.
//   - default bus widths
//   - default image base and the 6502 reset vector location
//   - loader state encoding
package fw_loader_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  // First byte of the boot image; the reset vector is pointed here.
  localparam logic [15:0] INSTRUCTION_BASE = 16'h0200;
  // 6502 reset vector low byte; the high byte lives at RESET_VECTOR+1.
  localparam logic [15:0] RESET_VECTOR     = 16'hFFFC;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VEC_LO,
    VEC_HI,
    HOLD,
    DONE,
    ERROR
  } fw_load_state_t;

  function automatic logic fw_state_busy(fw_load_state_t s);
    return (s == LOAD) || (s == VEC_LO) || (s == VEC_HI) || (s == HOLD);
  endfunction

endpackage

// File: rtl/fw_loader_if.sv
// Byte stream in (valid/ready) and memory write port out of the loader.
//   byte_in/byte_valid/byte_last : image source -> loader
//   byte_ready                   : loader -> image source
//   mem_we/mem_addr/mem_din      : loader -> memory write port
// modport slave  : the loader side
// modport master : the source/memory side
interface fw_loader_if
  import fw_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] byte_in;
  logic                  byte_valid;
  logic                  byte_last;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  modport master (
    output byte_in, byte_valid, byte_last,
    input  byte_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  byte_in, byte_valid, byte_last,
    output byte_ready, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/fw_loader_rst_stretch.sv
// CPU reset hold timer.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : (re)load the down-counter with HOLD_CYCLES
//   expired_o    : single-cycle pulse in the last hold cycle
// The counter reaches terminal count (1) in the HOLD_CYCLES-th cycle after
// the load, so the consumer leaves its hold state exactly HOLD_CYCLES
// cycles after the load edge.
module fw_loader_rst_stretch #(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(HOLD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = !load_i && (cnt_q == CW'(1));

endmodule

// File: rtl/fw_loader.sv
// Firmware loader: streams a byte image into memory at LOAD_BASE, writes the
// 6502 reset vector to point at it, then releases CPU reset after a hold.
//   clk_i, rst_i  : clock, async active-high reset
//   start_i       : 1-cycle pulse, begins a load from IDLE/DONE/ERROR
//   bus           : byte stream in + registered memory write port
//   cpu_reset_n_o : CPU reset (active-low), high only in DONE
//   busy_o        : LOAD/VEC_LO/VEC_HI/HOLD
//   done_o        : DONE
//   error_o       : ERROR
//   byte_count_o  : bytes accepted in the current load
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LOAD   | accepting image bytes, one write per handshake
// VEC_LO | writing reset vector low byte
// VEC_HI | writing reset vector high byte, arming hold timer
// HOLD   | CPU still in reset for RST_HOLD cycles
// DONE   | CPU released; start reloads
// ERROR  | image overflowed size limit or ran into the vector
module fw_loader
  import fw_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE = ADDR_WIDTH'(INSTRUCTION_BASE),
  parameter logic [ADDR_WIDTH-1:0] VEC_ADDR  = ADDR_WIDTH'(RESET_VECTOR),
  parameter int unsigned MAX_BYTES = 1024,
  parameter int unsigned RST_HOLD  = 8,
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BYTES) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  fw_loader_if.slave           bus,
  output logic                 cpu_reset_n_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] byte_count_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BYTES);

  fw_load_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rst_n_q, busy_q, done_q, err_q;
  logic                  ready;
  logic                  hs;
  logic                  hold_load;
  logic                  hold_expired;

  assign ready = (state_q == LOAD);
  assign hs    = bus.byte_valid && ready;

  fw_loader_rst_stretch #(
    .HOLD_CYCLES (RST_HOLD)
  ) u_rst_stretch (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (hold_load),
    .expired_o (hold_expired)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    hold_load = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d = LOAD;
          ptr_d   = LOAD_BASE;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (hs) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          din_d  = bus.byte_in;
          ptr_d  = ptr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q + CNT_WIDTH'(1);
          // last wins over both overflow conditions
          if (bus.byte_last) begin
            state_d = VEC_LO;
          end else if ((cnt_q + CNT_WIDTH'(1) == MAX_CNT) ||
                       (ptr_q + ADDR_WIDTH'(1) == VEC_ADDR)) begin
            state_d = ERROR;
          end
        end
      end
      VEC_LO: begin
        we_d    = 1'b1;
        addr_d  = VEC_ADDR;
        din_d   = LOAD_BASE[DATA_WIDTH-1:0];
        state_d = VEC_HI;
      end
      VEC_HI: begin
        we_d      = 1'b1;
        addr_d    = VEC_ADDR + ADDR_WIDTH'(1);
        din_d     = LOAD_BASE[DATA_WIDTH +: DATA_WIDTH];
        hold_load = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (hold_expired) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rst_n_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rst_n_q <= (state_d == DONE);
      busy_q  <= fw_state_busy(state_d);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERROR);
    end
  end

  assign bus.byte_ready = ready;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;
  assign cpu_reset_n_o  = rst_n_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = err_q;
  assign byte_count_o   = cnt_q;

endmodule
